// File: rtl/clkmon_sched.sv
// ---------------------------------------------------------------------------
// clkmon_sched
//   Round-robin scheduler that time-shares one edge-counting frequency meter
//   between N_CH test clocks. For each channel in turn it selects the clock,
//   lets the synchronizer settle, counts rising edges over WINDOW clk cycles,
//   compares the count against that channel's expected value and records the
//   verdict. One channel slot takes SETTLE + WINDOW + 1 clk cycles.
//
// Parameters
//   N_CH    number of monitored test clocks (>= 1)
//   CNT_W   width of the edge counter and of each expected count
//   WINDOW  measurement window in clk cycles (>= 2)
//   SETTLE  cycles spent in SELECT before counting (>= 3)
//   TOL     largest |count - expected| still reported as a pass
//
// Ports
//   clk       system clock, must exceed 2x the fastest test clock
//   rst_n     asynchronous reset, active HIGH (legacy name kept)
//   en        run the scheduler while high; low aborts the current channel
//   tst_clk   test clocks, asynchronous to clk
//   exp_cnt   expected edges per window, channel i at [i*CNT_W +: CNT_W]
//   ok        last evaluation of channel i passed
//   valid     channel i evaluated at least once since reset
//   meas_stb  one-cycle pulse per completed evaluation
//   meas_ch   channel of the last evaluation
//   meas_cnt  edge count of the last evaluation
//   busy      scheduler is not idle
//
// Optional build macro CLKMON_SCHED_STICKY_EN
//   Adds input clr and output fail[N_CH]: fail[i] latches any failing
//   evaluation of channel i until clr or reset; a failing evaluation in the
//   same cycle as clr leaves the bit set.
// ---------------------------------------------------------------------------
module clkmon_sched #(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 16,
    parameter int WINDOW = 1000,
    parameter int SETTLE = 4,
    parameter int TOL    = 2,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [N_CH-1:0]         tst_clk,
    input  logic [N_CH*CNT_W-1:0]   exp_cnt,
    output logic [N_CH-1:0]         ok,
    output logic [N_CH-1:0]         valid,
    output logic                    meas_stb,
    output logic [CH_W-1:0]         meas_ch,
    output logic [CNT_W-1:0]        meas_cnt,
    output logic                    busy
`ifdef CLKMON_SCHED_STICKY_EN
    ,
    input  logic                    clr,
    output logic [N_CH-1:0]         fail
`endif
);

    localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   TOL_V   = (CNT_W + 1)'(TOL);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        MEASURE = 2'd2,
        EVAL    = 2'd3
    } state_t;

    // Distance is formed one bit wider than the counter and always as
    // larger-minus-smaller, so it can neither wrap nor underflow.
    function automatic logic within_tol(input logic [CNT_W-1:0] cnt,
                                        input logic [CNT_W-1:0] expv);
        logic [CNT_W:0] a;
        logic [CNT_W:0] b;
        logic [CNT_W:0] d;
        a = {1'b0, cnt};
        b = {1'b0, expv};
        d = (a >= b) ? (a - b) : (b - a);
        return (d <= TOL_V);
    endfunction

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              sdly_q, sdly_d;

    logic [N_CH-1:0]   ok_q, ok_d;
    logic [N_CH-1:0]   valid_q, valid_d;
    logic              stb_q, stb_d;
    logic [CH_W-1:0]   mch_q, mch_d;
    logic [CNT_W-1:0]  mcnt_q, mcnt_d;
`ifdef CLKMON_SCHED_STICKY_EN
    logic [N_CH-1:0]   fail_q, fail_d;
`endif

    logic              rise;
    logic [CNT_W-1:0]  exp_sel;
    logic              pass;

    // Selected test clock feeds a 2FF synchronizer, then a delay flop used
    // for rising-edge detection. The mux follows ch_q, which only moves in
    // EVAL, so SELECT gives the chain SETTLE cycles to flush the old channel.
    assign rise    = sync2_q & ~sdly_q;
    assign exp_sel = exp_cnt[ch_q*CNT_W +: CNT_W];
    assign pass    = within_tol(cnt_q, exp_sel);

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        sync1_d = tst_clk[ch_q];
        sync2_d = sync1_q;
        sdly_d  = sync2_q;
        ok_d    = ok_q;
        valid_d = valid_q;
        stb_d   = 1'b0;
        mch_d   = mch_q;
        mcnt_d  = mcnt_q;
`ifdef CLKMON_SCHED_STICKY_EN
        fail_d  = clr ? '0 : fail_q;
`endif

        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                cnt_d   = '0;
                if (en) begin
                    state_d = SELECT;
                end
            end

            SELECT: begin
                cnt_d = '0;
                if (!en) begin
                    state_d = IDLE;
                end else if (timer_q == TMR_W'(SETTLE - 1)) begin
                    timer_d = '0;
                    state_d = MEASURE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            MEASURE: begin
                if (!en) begin
                    // Abort: partial count is discarded, channel is retried.
                    state_d = IDLE;
                end else begin
                    if (rise && (cnt_q != CNT_SAT)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (timer_q == TMR_W'(WINDOW - 1)) begin
                        timer_d = '0;
                        state_d = EVAL;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end

            EVAL: begin
                ok_d[ch_q]    = pass;
                valid_d[ch_q] = 1'b1;
                stb_d         = 1'b1;
                mch_d         = ch_q;
                mcnt_d        = cnt_q;
`ifdef CLKMON_SCHED_STICKY_EN
                if (!pass) begin
                    fail_d[ch_q] = 1'b1;
                end
`endif
                ch_d    = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;
                timer_d = '0;
                cnt_d   = '0;
                state_d = en ? SELECT : IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // rst_n is active high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            timer_q <= '0;
            cnt_q   <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sdly_q  <= 1'b0;
            ok_q    <= '0;
            valid_q <= '0;
            stb_q   <= 1'b0;
            mch_q   <= '0;
            mcnt_q  <= '0;
`ifdef CLKMON_SCHED_STICKY_EN
            fail_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sdly_q  <= sdly_d;
            ok_q    <= ok_d;
            valid_q <= valid_d;
            stb_q   <= stb_d;
            mch_q   <= mch_d;
            mcnt_q  <= mcnt_d;
`ifdef CLKMON_SCHED_STICKY_EN
            fail_q  <= fail_d;
`endif
        end
    end

    assign ok       = ok_q;
    assign valid    = valid_q;
    assign meas_stb = stb_q;
    assign meas_ch  = mch_q;
    assign meas_cnt = mcnt_q;
    assign busy     = (state_q != IDLE);
`ifdef CLKMON_SCHED_STICKY_EN
    assign fail     = fail_q;
`endif

endmodule

// File: tb/tb_clkmon_sched.sv
// ---------------------------------------------------------------------------
// tb_clkmon_sched
//   Randomized bench for clkmon_sched. Test clocks are periodic with an
//   integer period (in clk cycles) that divides the window, so every window
//   holds exactly WIN/period rising edges regardless of synchronizer phase.
//   The reference model tracks the slot timeline (SETTLE + WINDOW cycles of
//   work, then one evaluation cycle) and derives each verdict arithmetically.
//   A second instance with a narrow counter exercises saturation.
// ---------------------------------------------------------------------------
module tb_clkmon_sched;

    localparam int N    = 4;
    localparam int CW   = 16;
    localparam int WIN  = 200;
    localparam int SET  = 4;
    localparam int TOLP = 2;
    localparam int SLOT = SET + WIN + 1;
    localparam int SCW  = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [N-1:0]    tst_clk = '0;
    logic [N*CW-1:0] exp_cnt;
    logic [N-1:0]    ok, valid;
    logic            meas_stb;
    logic [1:0]      meas_ch;
    logic [CW-1:0]   meas_cnt;
    logic            busy;

    logic            en_s;
    logic [0:0]      tst_s = 1'b0;
    logic [SCW-1:0]  exp_s;
    logic [0:0]      ok_s, valid_s, mch_s;
    logic            stb_s, busy_s;
    logic [SCW-1:0]  mcnt_s;

`ifdef CLKMON_SCHED_STICKY_EN
    logic            clr;
    logic [N-1:0]    fail;
    logic            clr_s;
    logic [0:0]      fail_s;
`endif

    clkmon_sched #(.N_CH(N), .CNT_W(CW), .WINDOW(WIN), .SETTLE(SET), .TOL(TOLP)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .tst_clk(tst_clk), .exp_cnt(exp_cnt),
        .ok(ok), .valid(valid), .meas_stb(meas_stb), .meas_ch(meas_ch),
        .meas_cnt(meas_cnt), .busy(busy)
`ifdef CLKMON_SCHED_STICKY_EN
        , .clr(clr), .fail(fail)
`endif
    );

    clkmon_sched #(.N_CH(1), .CNT_W(SCW), .WINDOW(WIN), .SETTLE(SET), .TOL(TOLP)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en_s), .tst_clk(tst_s), .exp_cnt(exp_s),
        .ok(ok_s), .valid(valid_s), .meas_stb(stb_s), .meas_ch(mch_s),
        .meas_cnt(mcnt_s), .busy(busy_s)
`ifdef CLKMON_SCHED_STICKY_EN
        , .clr(clr_s), .fail(fail_s)
`endif
    );

    always #4 clk = ~clk;   // 125 MHz

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // ---------------- test clock generators ----------------
    int per[N];
    int ph[N];
    int ph_s = 0;
    int plist[10] = '{0, 2, 4, 5, 8, 10, 20, 25, 40, 50};

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (per[i] == 0) begin
                tst_clk[i] = 1'b0;
            end else begin
                ph[i] = (ph[i] + 1) % per[i];
                tst_clk[i] = (ph[i] < per[i] / 2);
            end
        end
        ph_s = (ph_s + 1) % 4;
        tst_s[0] = (ph_s < 2);
    end

    // ---------------- reference model ----------------
    function automatic int edges_in_window(input int p);
        int c;
        if (p == 0) return 0;
        c = WIN / p;
        if (c > (1 << CW) - 1) c = (1 << CW) - 1;
        return c;
    endfunction

    function automatic bit tol_pass(input int c, input int e);
        int d;
        d = (c > e) ? c - e : e - c;
        return d <= TOLP;
    endfunction

    int          m_ch, m_k, m_mch, m_mcnt;
    bit          m_act, m_stb;
    logic [N-1:0] m_ok, m_valid, m_fail;
    int          cyc = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            m_ch = 0; m_k = 0; m_act = 0; m_stb = 0;
            m_mch = 0; m_mcnt = 0; m_ok = '0; m_valid = '0; m_fail = '0;
        end else begin
            int c, e;
            bit p;
            m_stb = 0;
`ifdef CLKMON_SCHED_STICKY_EN
            if (clr) m_fail = '0;
`endif
            if (!m_act) begin
                if (en) begin m_act = 1; m_k = 0; end
            end else if (m_k < SET + WIN) begin
                if (!en) m_act = 0;
                else     m_k++;
            end else begin
                c = edges_in_window(per[m_ch]);
                e = int'(exp_cnt[m_ch*CW +: CW]);
                p = tol_pass(c, e);
                m_ok[m_ch] = p;
                m_valid[m_ch] = 1'b1;
                if (!p) m_fail[m_ch] = 1'b1;
                m_stb = 1; m_mch = m_ch; m_mcnt = c;
                m_ch = (m_ch + 1) % N;
                m_act = en; m_k = 0;
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    int s_last = -1;
    int s_seen = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("ok", 32'(ok), 32'(m_ok));
            chk("valid", 32'(valid), 32'(m_valid));
            chk("meas_stb", 32'(meas_stb), 32'(m_stb));
            chk("busy", 32'(busy), 32'(m_act));
            if (m_stb) begin
                chk("meas_ch", 32'(meas_ch), 32'(m_mch));
                chk("meas_cnt", 32'(meas_cnt), 32'(m_mcnt));
            end
`ifdef CLKMON_SCHED_STICKY_EN
            chk("fail", 32'(fail), 32'(m_fail));
`endif
            if (stb_s) begin
                s_seen++;
                chk("sat_cnt", 32'(mcnt_s), 32'd31);
                chk("sat_ok", 32'(ok_s), 32'd1);
                chk("sat_ch", 32'(mch_s), 32'd0);
                if (s_last >= 0) chk("sat_period", 32'(cyc - s_last), 32'(SLOT));
                s_last = cyc;
            end
        end else begin
            s_last = -1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_stb(input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!meas_stb && n < lim);
        if (!meas_stb) begin
            n_chk++; n_err++;
            $display("FAIL stb_timeout: got no strobe, required one within %0d cycles", lim);
        end
    endtask

    task automatic set_exp(input int c, input int e);
        exp_cnt[c*CW +: CW] = CW'(e);
    endtask

    int lit_cnt[N] = '{40, 20, 50, 8};

    initial begin
        int n, c, e;
        rst_n = 1'b1; en = 1'b0; en_s = 1'b0; exp_s = 5'd31;
`ifdef CLKMON_SCHED_STICKY_EN
        clr = 1'b0; clr_s = 1'b0;
`endif
        per[0] = 5; per[1] = 10; per[2] = 4; per[3] = 25;
        for (int i = 0; i < N; i++) begin ph[i] = 0; set_exp(i, lit_cnt[i]); end
        repeat (3) @(negedge clk);
        chk("rst_ok", 32'(ok), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_stb", 32'(meas_stb), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt", 32'(meas_cnt), 0);
        chk("rst_ch", 32'(meas_ch), 0);
        rst_n = 1'b0;
        @(negedge clk);
        en = 1'b1; en_s = 1'b1;

        // Round 1: all channels healthy
        for (int i = 0; i < N; i++) begin
            wait_stb(SLOT + 100, n);
            chk("r1_ch", 32'(meas_ch), 32'(i));
            chk("r1_cnt", 32'(meas_cnt), 32'(lit_cnt[i]));
        end
        chk("r1_ok", 32'(ok), 32'hF);
        chk("r1_valid", 32'(valid), 32'hF);

        // Round 2: ch2 stopped, ch0 off by 3 then by 2
        en = 1'b0;
        repeat (2) @(negedge clk);
        per[2] = 0;
        set_exp(0, 43);
        en = 1'b1;
        wait_stb(SLOT + 100, n);
        chk("tol3_ch", 32'(meas_ch), 0);
        chk("tol3_ok0", 32'(ok[0]), 0);
        set_exp(0, 42);
        wait_stb(SLOT + 100, n);
        wait_stb(SLOT + 100, n);
        chk("stop_ch", 32'(meas_ch), 2);
        chk("stop_cnt", 32'(meas_cnt), 0);
        chk("stop_ok", 32'(ok), 32'b1010);
        wait_stb(SLOT + 100, n);
        wait_stb(SLOT + 100, n);
        chk("tol2_ok0", 32'(ok[0]), 1);
`ifdef CLKMON_SCHED_STICKY_EN
        chk("sticky_fail", 32'(fail), 32'b0101);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
`endif

        // Abort 100 cycles into ch1's window, then resume ch1
        repeat (SET + 100) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        repeat (10) @(negedge clk);
        per[2] = 4;
        en = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!busy && n < 5);
        wait_stb(SLOT + 100, n);
        chk("abort_resume_ch", 32'(meas_ch), 1);
        chk("abort_resume_lat", 32'(n), 32'(SLOT));

        // Randomized run
        for (int it = 0; it < 30; it++) begin
            c = $urandom_range(0, N - 1);
            if ($urandom_range(0, 3) == 0) e = $urandom_range(0, 150);
            else begin
                e = edges_in_window(per[c]) + int'($urandom_range(0, 8)) - 4;
                if (e < 0) e = 0;
            end
            set_exp(c, e);
            repeat ($urandom_range(50, 600)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) begin
                en = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                per[$urandom_range(0, N - 1)] = plist[$urandom_range(0, 9)];
                en = 1'b1;
            end
        end

        // Reset in the middle of a window
        wait_stb(4 * SLOT, n);
        repeat (SET + 50) @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("mid_rst_ok", 32'(ok), 0);
        chk("mid_rst_valid", 32'(valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_cnt", 32'(meas_cnt), 0);
        chk("mid_rst_ch", 32'(meas_ch), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        wait_stb(SLOT + 100, n);
        chk("post_rst_ch", 32'(meas_ch), 0);
        wait_stb(SLOT + 100, n);
        chk("sat_strobes", 32'(s_seen >= 10), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
